// File: rtl/leaf_stage_pkg.sv
// Shared defaults, word type and width helper for the leaf buffering stage.
package leaf_stage_pkg;

  localparam int LEAF_DATA_W = 8;
  localparam int LEAF_DEPTH  = 4;

  typedef logic [LEAF_DATA_W-1:0] leaf_word_t;

  // Bits needed to hold n distinct values (0..n-1), never less than one.
  function automatic int clog2_safe(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/leaf_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
// Contents are not reset; the surrounding control masks unwritten entries.
module leaf_fifo_mem
  import leaf_stage_pkg::*;
#(
  parameter int DATA_W = LEAF_DATA_W,
  parameter int DEPTH  = LEAF_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/leaf_stream_fifo.sv
// Leaf FIFO stage with fill level, registered almost-full and input XOR checksum.
// Pushed word visible one cycle later; in_ready low only when full, with no same-cycle pop bypass.
module leaf_stream_fifo
  import leaf_stage_pkg::*;
#(
  parameter int DATA_W    = LEAF_DATA_W,
  parameter int DEPTH     = LEAF_DEPTH,
  parameter int AFULL_LVL = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_W-1:0]                out_data,
  output logic [clog2_safe(DEPTH+1)-1:0]   level,
  output logic                             almost_full,
  output logic [DATA_W-1:0]                checksum
);

  localparam int LVL_W = clog2_safe(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_afull;
  logic [DATA_W-1:0] r_csum;

  logic              w_push;
  logic              w_pop;
  logic [LVL_W-1:0]  w_level_nxt;
  logic [DATA_W-1:0] w_rdata;

  assign in_ready  = (r_level != LVL_W'(DEPTH));
  assign out_valid = (r_level != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + LVL_W'(1);
    else if (!w_push && w_pop) w_level_nxt = r_level - LVL_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_afull  <= 1'b0;
      r_csum   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_csum   <= r_csum ^ in_data;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= w_level_nxt;
      r_afull <= (w_level_nxt >= LVL_W'(AFULL_LVL));
    end
  end

  leaf_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (in_data),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  // Storage is never reset, so the head is masked to zero while empty.
  assign out_data    = out_valid ? w_rdata : '0;
  assign level       = r_level;
  assign almost_full = r_afull;
  assign checksum    = r_csum;

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// Bench for leaf_stream_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_leaf_stream_fifo;
  import leaf_stage_pkg::*;

  localparam int DEPTH     = 4;
  localparam int AFULL_LVL = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  leaf_word_t in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  leaf_word_t out_data;
  logic [2:0] level;
  logic       almost_full;
  leaf_word_t checksum;

  int checks = 0;
  int errors = 0;

  leaf_stream_fifo #(
    .DATA_W    (8),
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL_LVL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .almost_full (almost_full),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted words and a running XOR.
  leaf_word_t m_q[$];
  leaf_word_t m_csum = '0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_csum = '0;
      end else begin
        logic do_push, do_pop;
        do_push = in_valid && (m_q.size() < DEPTH);
        do_pop  = out_ready && (m_q.size() > 0);
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
          m_q.push_back(in_data);
          m_csum = m_csum ^ in_data;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("m_in_ready",  in_ready,    (m_q.size() < DEPTH));
      chk("m_out_valid", out_valid,   (m_q.size() > 0));
      chk("m_out_data",  out_data,    (m_q.size() > 0) ? m_q[0] : 8'h00);
      chk("m_level",     level,       m_q.size());
      chk("m_afull",     almost_full, (m_q.size() >= AFULL_LVL));
      chk("m_checksum",  checksum,    m_csum);
    end
  end

  task automatic step(input logic v, input leaf_word_t d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    leaf_word_t fill[4];
    leaf_word_t wrap[4];
    leaf_word_t sp[3];
    fill = '{8'h11, 8'h22, 8'h33, 8'h44};
    wrap = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    sp   = '{8'h10, 8'h20, 8'h66};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_level", level, 0);
      chk("idle_afull", almost_full, 0);
      chk("idle_checksum", checksum, 0);
      step(1'b0, 8'h00, 1'b0);
    end

    for (int i = 0; i < 4; i++) begin
      step(1'b1, fill[i], 1'b0);
      chk("fill_level", level, i + 1);
      chk("fill_afull", almost_full, (i + 1 >= 3));
    end
    chk("full_in_ready", in_ready, 0);
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    chk("full_level_hold", level, 4);
    chk("full_checksum", checksum, 8'h44);

    for (int i = 0; i < 4; i++) begin
      chk("drain_data", out_data, fill[i]);
      step(1'b0, 8'h00, 1'b1);
      chk("drain_level", level, 3 - i);
    end
    chk("drain_empty", out_valid, 0);

    for (int i = 0; i < 4; i++) step(1'b1, wrap[i], 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_data", out_data, wrap[i]);
      step(1'b0, 8'h00, 1'b1);
    end
    chk("wrap_checksum", checksum, 8'h44);

    step(1'b1, 8'h10, 1'b0);
    step(1'b1, 8'h20, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("sp_data", out_data, sp[i]);
      step(1'b1, 8'h66, 1'b1);
      chk("sp_level", level, 2);
    end
    chk("sp_checksum", checksum, 8'h12);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("sp_empty", level, 0);

    for (int i = 1; i <= 4; i++) step(1'b1, leaf_word_t'(i), 1'b0);
    chk("fp_in_ready_full", in_ready, 0);
    chk("fp_head", out_data, 8'h01);
    step(1'b1, 8'h77, 1'b1);
    chk("fp_level", level, 3);
    chk("fp_in_ready_next", in_ready, 1);
    chk("fp_head2", out_data, 8'h02);
    step(1'b1, 8'h77, 1'b0);
    chk("fp_accept", level, 4);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

    step(1'b1, 8'h81, 1'b0);
    step(1'b1, 8'h82, 1'b0);
    step(1'b1, 8'h83, 1'b0);
    in_valid = 1'b0;
    chk("ar_pre_level", level, 3);
    #2 rst = 1'b1;
    #1;
    chk("ar_in_ready", in_ready, 1);
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_data", out_data, 0);
    chk("ar_level", level, 0);
    chk("ar_afull", almost_full, 0);
    chk("ar_checksum", checksum, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 8'h5A, 1'b0);
    chk("ar_post_valid", out_valid, 1);
    chk("ar_post_data", out_data, 8'h5A);
    chk("ar_post_checksum", checksum, 8'h5A);
    step(1'b0, 8'h00, 1'b1);

    // Random traffic, with draining bias swept so the FIFO visits both full and empty.
    for (int i = 0; i < 3000; i++) begin
      int thr;
      thr = (i / 300) % 4;
      step($urandom_range(0, 3) >= 1, leaf_word_t'($urandom), $urandom_range(0, 3) < thr + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
